ray_hit_accumulator: RTL and testbench

- Sits directly downstream of RayUnit_FindClosestHit.
- A BVH leaf can hold more primitives than `AABB_TEST_UNIT_SIZE`, so the ray unit tests it over several consecutive batches and emits one closest-hit HitData per batch.
- This block keeps a running closest hit across all batches of one ray and emits one final HitData per ray over a valid/ready handshake.
- It also exports the current best T so upstream can cull primitives beyond it (ray MaxT feedback).

---
 rtl/ray_hit_accumulator_pkg.sv | 40 ++++
 rtl/hit_accum_select.sv | 23 ++
 rtl/ray_hit_accumulator.sv | 172 +++++++++++++++++
 tb/tb_ray_hit_accumulator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_hit_accumulator_pkg.sv
// ray_hit_accumulator_pkg
//   Shared types for the ray hit accumulator:
//   - Fixed:   signed Q16.16 fixed-point value (FIXED_WIDTH bits)
//   - HitData: closest-hit record emitted by the ray unit
//   - FixedInf(): largest positive Fixed, used as "no hit yet"
//   - hit_init(): empty accumulator value (bHit=0, T=FixedInf, rest 0)
//   The ray tag width is a global define so tag generators upstream agree on it.

`ifndef RAY_ID_WIDTH
`define RAY_ID_WIDTH 8
`endif

package ray_hit_accumulator_pkg;

  localparam int FIXED_WIDTH = 32;
  localparam int FIXED_FRAC  = 16;
  localparam int PRIM_WIDTH  = 16;

  typedef logic signed [FIXED_WIDTH-1:0] Fixed;

  typedef struct packed {
    logic                  bHit;
    Fixed                  T;
    logic [PRIM_WIDTH-1:0] PI;  // primitive index
    logic [PRIM_WIDTH-1:0] GI;  // geometry index
  } HitData;

  function automatic Fixed FixedInf();
    return {1'b0, {(FIXED_WIDTH-1){1'b1}}};
  endfunction

  function automatic HitData hit_init();
    HitData h;
    h      = '0;
    h.bHit = 1'b0;
    h.T    = FixedInf();
    return h;
  endfunction

endpackage

// File: rtl/hit_accum_select.sv
// hit_accum_select
//   Combinational merge of one batch result into a running closest hit.
//   Ports:
//     i_base   : current best hit (or the empty value on a starting beat)
//     i_hit    : closest hit of the incoming batch
//     o_merged : i_hit if it is a real hit strictly closer than i_base, else i_base
//   Strict less-than keeps the earlier batch on ties; a non-hit never wins,
//   whatever T it carries.

module hit_accum_select
  import ray_hit_accumulator_pkg::*;
(
  input  HitData i_base,
  input  HitData i_hit,
  output HitData o_merged
);

  logic w_take;

  assign w_take   = i_hit.bHit && ($signed(i_base.T) > $signed(i_hit.T));
  assign o_merged = w_take ? i_hit : i_base;

endmodule

// File: rtl/ray_hit_accumulator.sv
// ray_hit_accumulator
//   Keeps a running closest hit across all batches of one ray and emits one
//   final HitData per ray.
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     in_valid/in_ready     : batch input handshake
//     in_first/in_last      : batch position within a ray
//     in_ray_id             : ray tag, sampled on the starting beat only
//     in_hit                : per-batch closest hit
//     out_valid/out_ready   : final hit handshake
//     out_hit/out_ray_id    : final closest hit and its ray tag
//     out_batches           : batches accumulated for the ray (saturating)
//     cur_t                 : registered current best T for upstream culling
//     err                   : one-cycle pulse when in_first arrives mid-ray
//     dbg_state             : FSM state (0=IDLE, 1=ACCUM, 2=DONE)
//
//   Handshake: a transfer happens on a rising clk edge where valid && ready.
//   The producer holds valid and its payload stable until that edge; ready may
//   depend combinationally on the consumer (in_ready = out_ready in DONE), and
//   out_hit/out_ray_id/out_batches stay stable while out_valid && !out_ready.

module ray_hit_accumulator
  import ray_hit_accumulator_pkg::*;
#(
  parameter int RAY_ID_WIDTH = `RAY_ID_WIDTH,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [RAY_ID_WIDTH-1:0] in_ray_id,
  input  HitData                  in_hit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output HitData                  out_hit,
  output logic [RAY_ID_WIDTH-1:0] out_ray_id,
  output logic [CNT_WIDTH-1:0]    out_batches,
  output Fixed                    cur_t,
  output logic                    err,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_next;
  HitData                  r_acc;
  logic [RAY_ID_WIDTH-1:0] r_ray_id;
  logic [CNT_WIDTH-1:0]    r_cnt;
  Fixed                    r_cur_t;
  logic                    r_err;

  logic   w_accept;
  logic   w_start;
  logic   w_protocol_err;
  HitData w_base;
  HitData w_merged;
  HitData w_acc_next;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          w_state_next = in_last ? S_DONE : S_ACCUM;
        end
      end
      S_DONE: begin
        // A beat accepted in the same cycle as the output handshake starts
        // the next ray immediately.
        if (out_ready) begin
          if (w_accept) begin
            w_state_next = in_last ? S_DONE : S_ACCUM;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_ACCUM: in_ready = 1'b1;
      S_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign w_accept       = in_valid && in_ready;
  assign w_protocol_err = w_accept && (r_state == S_ACCUM) && in_first;
  // Any beat outside ACCUM starts a ray; in_first inside ACCUM restarts one.
  assign w_start        = w_accept && ((r_state != S_ACCUM) || in_first);
  assign w_base         = w_start ? hit_init() : r_acc;
  assign w_acc_next     = w_accept ? w_merged : r_acc;

  hit_accum_select u_select (
    .i_base   (w_base),
    .i_hit    (in_hit),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= hit_init();
      r_ray_id <= '0;
      r_cnt    <= '0;
      r_cur_t  <= FixedInf();
      r_err    <= 1'b0;
    end else begin
      r_err   <= w_protocol_err;
      // cur_t tracks the accumulator as it will be in the next state.
      r_cur_t <= (w_state_next == S_IDLE) ? FixedInf() : w_acc_next.T;
      if (w_accept) begin
        r_acc <= w_merged;
        if (w_start) begin
          r_ray_id <= in_ray_id;
          r_cnt    <= CNT_ONE;
        end else if (r_cnt != {CNT_WIDTH{1'b1}}) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  assign out_hit     = r_acc;
  assign out_ray_id  = r_ray_id;
  assign out_batches = r_cnt;
  assign cur_t       = r_cur_t;
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ray_hit_accumulator.sv
// tb_ray_hit_accumulator
//   Directed bench for ray_hit_accumulator. Inputs change 1 time unit after
//   the rising edge; outputs are sampled at that same point.

module tb_ray_hit_accumulator;
  import ray_hit_accumulator_pkg::*;

  localparam int RW = 8;
  localparam int CW = 8;

  localparam Fixed INF  = 32'sh7FFF_FFFF;
  localparam Fixed T0P5 = 32'sh0000_8000;
  localparam Fixed T1   = 32'sh0001_0000;
  localparam Fixed T1P5 = 32'sh0001_8000;
  localparam Fixed T2   = 32'sh0002_0000;
  localparam Fixed T3   = 32'sh0003_0000;
  localparam Fixed T4   = 32'sh0004_0000;
  localparam Fixed T5   = 32'sh0005_0000;
  localparam Fixed T6   = 32'sh0006_0000;
  localparam Fixed T7   = 32'sh0007_0000;
  localparam Fixed T8   = 32'sh0008_0000;
  localparam Fixed T9   = 32'sh0009_0000;
  localparam Fixed T10  = 32'sh000A_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_first;
  logic          in_last;
  logic [RW-1:0] in_ray_id;
  HitData        in_hit;
  logic          out_valid;
  logic          out_ready;
  HitData        out_hit;
  logic [RW-1:0] out_ray_id;
  logic [CW-1:0] out_batches;
  Fixed          cur_t;
  logic          err;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  ray_hit_accumulator #(
    .RAY_ID_WIDTH (RW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_first    (in_first),
    .in_last     (in_last),
    .in_ray_id   (in_ray_id),
    .in_hit      (in_hit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_hit     (out_hit),
    .out_ray_id  (out_ray_id),
    .out_batches (out_batches),
    .cur_t       (cur_t),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic HitData mk(input logic b, input Fixed t, input logic [15:0] pi);
    HitData h;
    h.bHit = b;
    h.T    = t;
    h.PI   = pi;
    h.GI   = ~pi;
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic l, input logic [RW-1:0] id, input HitData h);
    in_valid  = 1'b1;
    in_first  = f;
    in_last   = l;
    in_ray_id = id;
    in_hit    = h;
  endtask

  task automatic beat(input logic f, input logic l, input logic [RW-1:0] id, input HitData h);
    drive(f, l, id, h);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid got %b want 0", out_valid); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset.err got %b want 0", err); end
    n_vec++; if (cur_t !== INF) begin n_err++; $display("FAIL reset.cur_t got %h want %h", cur_t, INF); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset.in_ready got %b want 1", in_ready); end
    n_vec++; if (out_ray_id !== 8'd0) begin n_err++; $display("FAIL reset.out_ray_id got %0d want 0", out_ray_id); end
    n_vec++; if (out_batches !== 8'd0) begin n_err++; $display("FAIL reset.out_batches got %0d want 0", out_batches); end
    n_vec++; if (out_hit.bHit !== 1'b0 || out_hit.T !== INF) begin n_err++; $display("FAIL reset.acc got b=%b T=%h want b=0 T=%h", out_hit.bHit, out_hit.T, INF); end
  endtask

  task automatic test_three_batches();
    beat(1'b1, 1'b0, 8'd5, mk(1'b1, T5, 16'd1));
    n_vec++; if (cur_t !== T5) begin n_err++; $display("FAIL three.cur_t1 got %h want %h", cur_t, T5); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL three.out_valid1 got %b want 0", out_valid); end
    beat(1'b0, 1'b0, 8'd77, mk(1'b1, T2, 16'd2));
    n_vec++; if (cur_t !== T2) begin n_err++; $display("FAIL three.cur_t2 got %h want %h", cur_t, T2); end
    beat(1'b0, 1'b1, 8'd78, mk(1'b1, T3, 16'd3));
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL three.out_valid got %b want 1", out_valid); end
    n_vec++; if (out_hit.T !== T2) begin n_err++; $display("FAIL three.T got %h want %h", out_hit.T, T2); end
    n_vec++; if (out_hit.bHit !== 1'b1) begin n_err++; $display("FAIL three.bHit got %b want 1", out_hit.bHit); end
    n_vec++; if (out_hit.PI !== 16'd2 || out_hit.GI !== ~16'd2) begin n_err++; $display("FAIL three.PI got %0d/%h want 2/%h", out_hit.PI, out_hit.GI, ~16'd2); end
    n_vec++; if (out_ray_id !== 8'd5) begin n_err++; $display("FAIL three.ray_id got %0d want 5", out_ray_id); end
    n_vec++; if (out_batches !== 8'd3) begin n_err++; $display("FAIL three.batches got %0d want 3", out_batches); end
    n_vec++; if (cur_t !== T2) begin n_err++; $display("FAIL three.cur_t_done got %h want %h", cur_t, T2); end
    consume();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL three.drain got %b want 0", out_valid); end
    n_vec++; if (cur_t !== INF) begin n_err++; $display("FAIL three.cur_t_idle got %h want %h", cur_t, INF); end
  endtask

  task automatic test_single_nohit();
    beat(1'b1, 1'b1, 8'd6, mk(1'b0, T1, 16'd40));
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single.out_valid got %b want 1", out_valid); end
    n_vec++; if (out_hit.bHit !== 1'b0) begin n_err++; $display("FAIL single.bHit got %b want 0", out_hit.bHit); end
    n_vec++; if (out_hit.T !== INF) begin n_err++; $display("FAIL single.T got %h want %h", out_hit.T, INF); end
    n_vec++; if (out_batches !== 8'd1) begin n_err++; $display("FAIL single.batches got %0d want 1", out_batches); end
    consume();
  endtask

  task automatic test_tie();
    beat(1'b1, 1'b0, 8'd7, mk(1'b1, T4, 16'd7));
    beat(1'b0, 1'b0, 8'd7, mk(1'b1, T4, 16'd9));
    n_vec++; if (cur_t !== T4) begin n_err++; $display("FAIL tie.cur_t got %h want %h", cur_t, T4); end
    beat(1'b0, 1'b1, 8'd7, mk(1'b0, T0P5, 16'd3));
    n_vec++; if (out_hit.PI !== 16'd7) begin n_err++; $display("FAIL tie.PI got %0d want 7", out_hit.PI); end
    n_vec++; if (out_hit.T !== T4) begin n_err++; $display("FAIL tie.T got %h want %h", out_hit.T, T4); end
    n_vec++; if (out_batches !== 8'd3) begin n_err++; $display("FAIL tie.batches got %0d want 3", out_batches); end
    consume();
  endtask

  task automatic test_backpressure();
    beat(1'b1, 1'b1, 8'd9, mk(1'b1, T1P5, 16'd11));
    // Next ray's first beat waits while the consumer stalls.
    drive(1'b1, 1'b0, 8'd10, mk(1'b1, T7, 16'd12));
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp.in_ready[%0d] got %b want 0", i, in_ready); end
      n_vec++; if (out_valid !== 1'b1 || out_hit.T !== T1P5 || out_hit.PI !== 16'd11 || out_ray_id !== 8'd9 || out_batches !== 8'd1) begin
        n_err++; $display("FAIL bp.hold[%0d] got v=%b T=%h PI=%0d id=%0d n=%0d want v=1 T=%h PI=11 id=9 n=1", i, out_valid, out_hit.T, out_hit.PI, out_ray_id, out_batches, T1P5);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp.in_ready_release got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp.accum_valid got %b want 0", out_valid); end
    n_vec++; if (cur_t !== T7) begin n_err++; $display("FAIL bp.cur_t got %h want %h", cur_t, T7); end
    beat(1'b0, 1'b1, 8'd10, mk(1'b1, T8, 16'd13));
    n_vec++; if (out_valid !== 1'b1 || out_ray_id !== 8'd10 || out_hit.T !== T7 || out_batches !== 8'd2) begin
      n_err++; $display("FAIL bp.next_ray got v=%b id=%0d T=%h n=%0d want v=1 id=10 T=%h n=2", out_valid, out_ray_id, out_hit.T, out_batches, T7);
    end
    consume();
  endtask

  task automatic test_first_in_accum();
    beat(1'b1, 1'b0, 8'd1, mk(1'b1, T3, 16'd20));
    beat(1'b0, 1'b0, 8'd1, mk(1'b1, T2, 16'd21));
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL restart.err_before got %b want 0", err); end
    beat(1'b1, 1'b1, 8'd2, mk(1'b1, T6, 16'd22));
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL restart.err got %b want 1", err); end
    n_vec++; if (out_ray_id !== 8'd2) begin n_err++; $display("FAIL restart.ray_id got %0d want 2", out_ray_id); end
    n_vec++; if (out_hit.T !== T6 || out_hit.PI !== 16'd22) begin n_err++; $display("FAIL restart.hit got T=%h PI=%0d want T=%h PI=22", out_hit.T, out_hit.PI, T6); end
    n_vec++; if (out_batches !== 8'd1) begin n_err++; $display("FAIL restart.batches got %0d want 1", out_batches); end
    tick();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL restart.err_pulse got %b want 0", err); end
    consume();
  endtask

  task automatic test_reset_mid_ray();
    beat(1'b1, 1'b0, 8'd3, mk(1'b1, T1, 16'd30));
    beat(1'b0, 1'b0, 8'd3, mk(1'b1, T0P5, 16'd31));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid.out_valid got %b want 0", out_valid); end
    n_vec++; if (cur_t !== INF) begin n_err++; $display("FAIL rstmid.cur_t got %h want %h", cur_t, INF); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rstmid.state got %0d want 0", dbg_state); end
    beat(1'b1, 1'b0, 8'd4, mk(1'b1, T9, 16'd32));
    beat(1'b0, 1'b1, 8'd4, mk(1'b1, T10, 16'd33));
    n_vec++; if (out_hit.T !== T9 || out_hit.PI !== 16'd32 || out_ray_id !== 8'd4 || out_batches !== 8'd2) begin
      n_err++; $display("FAIL rstmid.result got T=%h PI=%0d id=%0d n=%0d want T=%h PI=32 id=4 n=2", out_hit.T, out_hit.PI, out_ray_id, out_batches, T9);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 8'd20, mk(1'b1, T2, 16'd50));
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_ray_id !== 8'd20 || out_hit.T !== T2) begin
      n_err++; $display("FAIL b2b.first got v=%b id=%0d T=%h want v=1 id=20 T=%h", out_valid, out_ray_id, out_hit.T, T2);
    end
    drive(1'b1, 1'b1, 8'd21, mk(1'b1, T3, 16'd51));
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_ray_id !== 8'd21 || out_hit.T !== T3 || out_batches !== 8'd1) begin
      n_err++; $display("FAIL b2b.second got v=%b id=%0d T=%h n=%0d want v=1 id=21 T=%h n=1", out_valid, out_ray_id, out_hit.T, out_batches, T3);
    end
    tick();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b.drain got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    beat(1'b1, 1'b0, 8'd30, mk(1'b1, T5, 16'd60));
    for (int i = 0; i < 298; i++) begin
      beat(1'b0, 1'b0, 8'd30, mk(1'b1, T8, 16'd61));
    end
    beat(1'b0, 1'b1, 8'd30, mk(1'b1, T6, 16'd62));
    n_vec++; if (out_batches !== 8'hFF) begin n_err++; $display("FAIL sat.batches got %0d want 255", out_batches); end
    n_vec++; if (out_hit.PI !== 16'd60) begin n_err++; $display("FAIL sat.PI got %0d want 60", out_hit.PI); end
    consume();
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer and report
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_ray_id = '0;
    in_hit    = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_three_batches();
    test_single_nohit();
    test_tie();
    test_backpressure();
    test_first_in_accum();
    test_reset_mid_ray();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
